// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] INST_NOP   = 32'h0000_0000;
    localparam logic        RW_READ    = 1'b1;
    localparam logic        RW_WRITE   = 1'b0;

    // A fetch address is usable only when word aligned and no higher than the last word.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] last_addr);
        return (addr[1:0] == 2'b00) && (addr <= last_addr);
    endfunction

endpackage

// File: rtl/imem_boot_ctrl.sv
// Owns the instruction memory port: streams a boot image in, then serves CPU fetches.
// Writes are registered one cycle and committed by the memory on the following negedge.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES  = 60,
    parameter int BOOT_WORDS = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        reload,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        cpu_stall,
    output logic        boot_done,
    output logic        err_oob,
    output logic [31:0] mem_addr,
    output logic        mem_rw,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int              CNT_W     = $clog2(BOOT_WORDS + 1);
    localparam logic [31:0]     LAST_ADDR = 32'(MEM_BYTES - WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_WORDS - 1);

    state_e           state_r;
    state_e           state_s;
    logic [31:0]      wr_addr_r;
    logic [31:0]      wr_hold_addr_r;
    logic [31:0]      din_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_pend_r;
    logic             err_oob_r;
    logic             ready_s;
    logic             hs_s;
    logic             fetch_s;
    logic             pc_ok_s;

    assign ready_s = (state_r == LOAD) && !reload;
    assign hs_s    = ld_valid && ready_s;
    assign fetch_s = (state_r == RUN) && !wr_pend_r;
    assign pc_ok_s = addr_legal(pc, LAST_ADDR);

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; reload takes priority over a handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = LOAD;
            LOAD: begin
                if (reload) begin
                    state_s = LOAD;
                end else if (hs_s && (ld_last || (count_r == CNT_LAST))) begin
                    state_s = RUN;
                end else begin
                    state_s = LOAD;
                end
            end
            RUN: begin
                if (reload) begin
                    state_s = LOAD;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Load datapath: write staging, address/count tracking and the sticky range error.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_addr_r      <= 32'h0000_0000;
            wr_hold_addr_r <= 32'h0000_0000;
            din_r          <= 32'h0000_0000;
            count_r        <= '0;
            wr_pend_r      <= 1'b0;
            err_oob_r      <= 1'b0;
        end else begin
            wr_pend_r <= hs_s;
            if (hs_s) begin
                wr_hold_addr_r <= wr_addr_r;
                din_r          <= ld_data;
            end
            if (reload && (state_r != IDLE)) begin
                wr_addr_r <= 32'h0000_0000;
                count_r   <= '0;
            end else if (hs_s) begin
                wr_addr_r <= wr_addr_r + 32'(WORD_BYTES);
                count_r   <= count_r + CNT_W'(1);
            end
            if (fetch_s && !pc_ok_s) begin
                err_oob_r <= 1'b1;
            end
        end
    end

    // Port ownership and CPU-facing outputs; a pending write always owns the memory port.
    always_comb begin
        ld_ready  = ready_s;
        cpu_stall = !fetch_s;
        boot_done = fetch_s;
        err_oob   = err_oob_r;
        mem_rw    = wr_pend_r ? RW_WRITE : RW_READ;
        mem_din   = din_r;
        if (wr_pend_r) begin
            mem_addr = wr_hold_addr_r;
        end else if (fetch_s && pc_ok_s) begin
            mem_addr = pc;
        end else begin
            mem_addr = 32'h0000_0000;
        end
        if (fetch_s && pc_ok_s) begin
            inst = mem_dout;
        end else begin
            inst = INST_NOP;
        end
    end

endmodule
